// File: rtl/envseq_ramp.sv
// Multi-stage linearly interpolated envelope generator with gate-held sustain and looping.
// Optional eoc end-of-stage pulse output is built when ENVSEQ_RAMP_EOC_EN is defined.
module envseq_ramp #(
  parameter int BITS   = 16,
  parameter int STAGES = 4,
  parameter int TW     = 4,
  parameter int MAXLOG = 12,
  parameter int TSCALE = 300
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        trigger,
  input  logic                        gate,
  input  logic [STAGES*BITS-1:0]      levels,
  input  logic [STAGES*TW-1:0]        times,
  input  logic [$clog2(STAGES)-1:0]   sustain_stage,
  input  logic                        sus_on,
  input  logic                        loop_en,
  output logic signed [BITS-1:0]      envOut,
  output logic [$clog2(STAGES)-1:0]   stage,
  output logic                        busy
`ifdef ENVSEQ_RAMP_EOC_EN
  ,
  output logic                        eoc
`endif
);

  localparam int SW  = $clog2(STAGES);
  localparam int PSW = (TSCALE > 1) ? $clog2(TSCALE) : 1;
  localparam int PW  = BITS + 1 + MAXLOG;
  localparam logic [SW-1:0]     LAST   = SW'(STAGES - 1);
  localparam logic [PSW-1:0]    PS_TOP = PSW'(TSCALE - 1);
  localparam logic [MAXLOG-1:0] ONES   = '1;

  typedef enum logic [1:0] {IDLE, RUN, SUSTAIN} state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [MAXLOG-1:0]        t_q, t_d;
  logic [PSW-1:0]           presc_q, presc_d;
  logic signed [BITS-1:0]   s_q, s_d;
  logic signed [BITS-1:0]   env_q, env_d;
  logic                     trig_q;

  logic signed [BITS-1:0]   lvl [STAGES];
  logic [TW-1:0]            tm [STAGES];
  logic signed [BITS-1:0]   lvl_k, interp, s_start;
  logic [TW-1:0]            tm_k;
  int                       t_log;
  logic [MAXLOG-1:0]        t_end, t_nx;
  logic                     tick, last_t, end_evt, rise, adv;
  logic signed [BITS:0]     diff;
  logic signed [PW-1:0]     prod, shifted;

  always_comb begin : unpack_c
    for (int i = 0; i < STAGES; i++) begin
      lvl[i] = levels[i*BITS +: BITS];
      tm[i]  = times[i*TW +: TW];
    end
  end

  // Stage length is 2^T ticks, so interpolation is a multiply followed by an arithmetic shift.
  always_comb begin : interp_c
    lvl_k   = lvl[stage_q];
    tm_k    = tm[stage_q];
    t_log   = (int'(tm_k) > MAXLOG) ? MAXLOG : int'(tm_k);
    t_end   = ONES >> (MAXLOG - t_log);
    tick    = (state_q == RUN) && (presc_q == PS_TOP);
    last_t  = (t_q == t_end);
    end_evt = ena && tick && last_t;
    t_nx    = (tick && !last_t) ? t_q + MAXLOG'(1) : t_q;
    diff    = {lvl_k[BITS-1], lvl_k} - {s_q[BITS-1], s_q};
    prod    = PW'(diff) * PW'($signed({1'b0, t_nx}));
    shifted = prod >>> t_log;
    interp  = s_q + shifted[BITS-1:0];
    rise    = trigger && !trig_q;
    s_start = end_evt ? lvl_k : env_q;
  end

  always_comb begin : next_c
    state_d = state_q;
    stage_d = stage_q;
    t_d     = t_q;
    presc_d = presc_q;
    s_d     = s_q;
    env_d   = env_q;
    adv     = 1'b0;
    if (ena) begin
      case (state_q)
        RUN: begin
          presc_d = tick ? '0 : presc_q + PSW'(1);
          t_d     = t_nx;
          env_d   = interp;
          if (end_evt) begin
            env_d = lvl_k;
            s_d   = lvl_k;
            t_d   = '0;
            if (sus_on && (stage_q == sustain_stage) && gate) state_d = SUSTAIN;
            else adv = 1'b1;
          end
        end
        SUSTAIN: if (!gate) adv = 1'b1;
        default: ;
      endcase
      if (adv) begin
        presc_d = '0;
        if (stage_q != LAST) begin
          stage_d = stage_q + SW'(1);
          state_d = RUN;
        end else if (loop_en) begin
          stage_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      // A trigger beats a simultaneous end-of-stage and restarts from the level just reached.
      if (rise) begin
        state_d = RUN;
        stage_d = '0;
        t_d     = '0;
        presc_d = '0;
        s_d     = s_start;
        env_d   = s_start;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      t_q     <= '0;
      presc_q <= '0;
      s_q     <= '0;
      env_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      t_q     <= t_d;
      presc_q <= presc_d;
      s_q     <= s_d;
      env_q   <= env_d;
      trig_q  <= trigger;
    end
  end

`ifdef ENVSEQ_RAMP_EOC_EN
  logic eoc_q;
  always_ff @(posedge clk) begin
    if (!rst) eoc_q <= 1'b0;
    else eoc_q <= end_evt ||
                  (ena && (state_q == SUSTAIN) && !gate && (stage_q == LAST) && !loop_en && !rise);
  end
  assign eoc = eoc_q;
`endif

  assign envOut = env_q;
  assign stage  = stage_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_envseq_ramp.sv
// Directed bench for envseq_ramp: ramps, sustain, legato retrigger, prescaler/ena, loop, reset.
// A TSCALE=1 instance covers most scenarios; a TSCALE=3 instance covers prescaling.
module tb_envseq_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ena, trigger, gate, sus_on, loop_en;
  logic [63:0] levels;
  logic [15:0] times;
  logic [1:0]  sustain_stage;
  logic signed [15:0] env1, env3;
  logic [1:0] stg1, stg3;
  logic busy1, busy3;
`ifdef ENVSEQ_RAMP_EOC_EN
  logic eoc1, eoc3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  envseq_ramp #(.BITS(16), .STAGES(4), .TW(4), .MAXLOG(12), .TSCALE(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .trigger(trigger), .gate(gate),
    .levels(levels), .times(times), .sustain_stage(sustain_stage),
    .sus_on(sus_on), .loop_en(loop_en),
    .envOut(env1), .stage(stg1), .busy(busy1)
`ifdef ENVSEQ_RAMP_EOC_EN
    , .eoc(eoc1)
`endif
  );

  envseq_ramp #(.BITS(16), .STAGES(4), .TW(4), .MAXLOG(12), .TSCALE(3)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .trigger(trigger), .gate(gate),
    .levels(levels), .times(times), .sustain_stage(sustain_stage),
    .sus_on(sus_on), .loop_en(loop_en),
    .envOut(env3), .stage(stg3), .busy(busy3)
`ifdef ENVSEQ_RAMP_EOC_EN
    , .eoc(eoc3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy1 === 1'b1; i++) step();
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: busy got %b expected 0", name, busy1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (env1 !== 16'h0000 || stg1 !== 2'd0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset1: env %h stage %0d busy %b expected 0000 0 0", env1, stg1, busy1);
    end
    n_cmp++;
    if (env3 !== 16'h0000 || stg3 !== 2'd0 || busy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset3: env %h stage %0d busy %b expected 0000 0 0", env3, stg3, busy3);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_ramp();
    logic [15:0] e [15];
    logic [1:0]  s [15];
    e = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h3000, 16'h2000, 16'h2000,
          16'h1C00, 16'h1800, 16'h1400, 16'h1000, 16'h0C00, 16'h0800, 16'h0400, 16'h0000};
    s = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    pulse_trigger();
    n_cmp++;
    if (env1 !== 16'h0000 || stg1 !== 2'd0 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_start: env %h stage %0d busy %b expected 0000 0 1", env1, stg1, busy1);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (env1 !== e[i]) begin
        n_bad++;
        $display("FAIL basic_env[%0d]: got %h expected %h", i, env1, e[i]);
      end
      if (i < 14) begin
        n_cmp++;
        if (stg1 !== s[i]) begin
          n_bad++;
          $display("FAIL basic_stage[%0d]: got %0d expected %0d", i, stg1, s[i]);
        end
      end
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_end: got %b expected 0", busy1);
    end
  endtask

  task automatic test_sustain();
    int bad;
    sus_on = 1'b1;
    sustain_stage = 2'd1;
    gate = 1'b1;
    pulse_trigger();
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (env1 !== 16'h2000 || stg1 !== 2'd1) begin
      n_bad++;
      $display("FAIL sus_arrive: env %h stage %0d expected 2000 1", env1, stg1);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      n_cmp++;
      if (env1 !== 16'h2000 || stg1 !== 2'd1 || busy1 !== 1'b1) begin
        n_bad++;
        $display("FAIL sus_hold[%0d]: env %h stage %0d busy %b expected 2000 1 1", i, env1, stg1, busy1);
      end
    end
    gate = 1'b0;
    step();
    n_cmp++;
    if (stg1 !== 2'd2 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL sus_release: stage %0d busy %b expected 2 1", stg1, busy1);
    end
    sus_on = 1'b0;
    wait_idle("sustain");
  endtask

  task automatic test_legato();
    logic [15:0] e [4];
    logic [1:0]  s [4];
    e = '{16'h1C00, 16'h2800, 16'h3400, 16'h4000};
    s = '{2'd0, 2'd0, 2'd0, 2'd1};
    pulse_trigger();
    for (int i = 0; i < 11; i++) step();
    n_cmp++;
    if (env1 !== 16'h1000 || stg1 !== 2'd3) begin
      n_bad++;
      $display("FAIL legato_pre: env %h stage %0d expected 1000 3", env1, stg1);
    end
    pulse_trigger();
    n_cmp++;
    if (env1 !== 16'h1000 || stg1 !== 2'd0) begin
      n_bad++;
      $display("FAIL legato_start: env %h stage %0d expected 1000 0", env1, stg1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (env1 !== e[i] || stg1 !== s[i]) begin
        n_bad++;
        $display("FAIL legato_ramp[%0d]: env %h stage %0d expected %h %0d", i, env1, stg1, e[i], s[i]);
      end
    end
    wait_idle("legato");
  endtask

  task automatic test_trigger_at_end();
    pulse_trigger();
    for (int i = 0; i < 3; i++) step();
    pulse_trigger();
    n_cmp++;
    if (env1 !== 16'h4000 || stg1 !== 2'd0 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL trig_end_start: env %h stage %0d busy %b expected 4000 0 1", env1, stg1, busy1);
    end
    step();
    n_cmp++;
    if (env1 !== 16'h4000 || stg1 !== 2'd0) begin
      n_bad++;
      $display("FAIL trig_end_flat: env %h stage %0d expected 4000 0", env1, stg1);
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (env1 !== 16'h4000 || stg1 !== 2'd1) begin
      n_bad++;
      $display("FAIL trig_end_next: env %h stage %0d expected 4000 1", env1, stg1);
    end
    wait_idle("trig_end");
  endtask

  task automatic test_prescale_ena();
    reset_pulse();
    pulse_trigger();
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (env3 !== 16'h1000 || stg3 !== 2'd0) begin
      n_bad++;
      $display("FAIL pre_first_tick: env %h stage %0d expected 1000 0", env3, stg3);
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (env3 !== 16'h1000 || stg3 !== 2'd0) begin
        n_bad++;
        $display("FAIL ena_frozen[%0d]: env %h stage %0d expected 1000 0", i, env3, stg3);
      end
    end
    ena = 1'b1;
    step();
    n_cmp++;
    if (env3 !== 16'h1000) begin
      n_bad++;
      $display("FAIL ena_resume: env %h expected 1000", env3);
    end
    step();
    n_cmp++;
    if (env3 !== 16'h2000) begin
      n_bad++;
      $display("FAIL ena_tick2: env %h expected 2000", env3);
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (env3 !== 16'h3000 || stg3 !== 2'd0) begin
      n_bad++;
      $display("FAIL ena_before_end: env %h stage %0d expected 3000 0", env3, stg3);
    end
    step();
    n_cmp++;
    if (env3 !== 16'h4000 || stg3 !== 2'd1) begin
      n_bad++;
      $display("FAIL ena_stage_end: env %h stage %0d expected 4000 1", env3, stg3);
    end
  endtask

  task automatic test_loop();
    reset_pulse();
    loop_en = 1'b1;
    pulse_trigger();
    for (int i = 0; i < 14; i++) step();
    step();
    n_cmp++;
    if (env1 !== 16'h0000 || stg1 !== 2'd0 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL loop_wrap: env %h stage %0d busy %b expected 0000 0 1", env1, stg1, busy1);
    end
    step();
    n_cmp++;
    if (env1 !== 16'h1000 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL loop_ramp: env %h busy %b expected 1000 1", env1, busy1);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (env1 !== 16'h0000 || stg1 !== 2'd0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_reset: env %h stage %0d busy %b expected 0000 0 0", env1, stg1, busy1);
    end
    rst = 1'b1;
    loop_en = 1'b0;
    step();
  endtask

`ifdef ENVSEQ_RAMP_EOC_EN
  task automatic test_eoc();
    int pulses;
    logic exp_eoc;
    reset_pulse();
    pulses = 0;
    pulse_trigger();
    for (int i = 0; i < 21; i++) begin
      exp_eoc = (i == 4 || i == 6 || i == 7 || i == 15);
      n_cmp++;
      if (eoc1 !== exp_eoc) begin
        n_bad++;
        $display("FAIL eoc[%0d]: got %b expected %b", i, eoc1, exp_eoc);
      end
      if (eoc1 === 1'b1) pulses++;
      step();
    end
    n_cmp++;
    if (pulses != 4) begin
      n_bad++;
      $display("FAIL eoc_count: got %0d expected 4", pulses);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    ena = 1'b1;
    trigger = 1'b0;
    gate = 1'b0;
    sus_on = 1'b0;
    loop_en = 1'b0;
    sustain_stage = 2'd0;
    levels = '0;
    levels[15:0]  = 16'h4000;
    levels[31:16] = 16'h2000;
    levels[47:32] = 16'h2000;
    levels[63:48] = 16'h0000;
    times = '0;
    times[3:0]   = 4'd2;
    times[7:4]   = 4'd1;
    times[11:8]  = 4'd0;
    times[15:12] = 4'd3;

    test_reset();
    test_basic_ramp();
    test_sustain();
    test_legato();
    test_trigger_at_end();
    test_prescale_ena();
    test_loop();
`ifdef ENVSEQ_RAMP_EOC_EN
    test_eoc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/envseq_ramp.md
Name: envseq_ramp

Overview:
- Parametrised successor to the stepped envelope sequencer.
- Generates a multi-stage, linearly interpolated envelope, with optional gate-held sustain and looping.
- Stage durations are powers of two of prescaled ticks, so interpolation needs only a multiply and a shift, not a divide.
- Sits between a trigger source (bitseq) and a dsp_mult VCA stage; output is the codebase signed sample type.

Parameters:
- BITS, 16, sample width of levels and envOut (signed two's complement).
- STAGES, 4, number of ramp stages (>=2).
- TW, 4, width of each per-stage log2 duration field.
- MAXLOG, 12, upper bound on log2 duration; times fields above it are clamped to MAXLOG.
- TSCALE, 300, clock cycles per envelope tick (prescaler, >=1).

Ports:
- clk  in  1  DSP clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- ena  in  1  clock enable; low freezes all state and holds envOut.
- trigger  in  1  a rising edge starts or restarts the envelope.
- gate  in  1  holds the sustain stage while high.
- levels  in  STAGES*BITS  target level per stage, signed; stage k in slice k.
- times  in  STAGES*TW  log2 tick count per stage, unsigned.
- sustain_stage  in  clog2(STAGES)  stage whose end level is held while gate is high.
- sus_on  in  1  enables sustain behaviour.
- loop_en  in  1  after the last stage, restart at stage 0 instead of stopping.
- envOut  out  BITS  envelope sample, signed, registered.
- stage  out  clog2(STAGES)  current stage index.
- busy  out  1  high in RUN or SUSTAIN.

Behaviour:
- Reset (rst low at a clk edge): envOut=0, stage=0, busy=0, state=IDLE, prescaler=0, t=0, trigger history=0. Reset mid-ramp aborts immediately.
- Trigger detection: trigger is registered every cycle, even while ena is low. A rise is seen when current=1 and previous=0. Rises seen while ena is low are dropped.
- Tick: the prescaler counts 0..TSCALE-1 while state is RUN and ena is high; tick is asserted on wrap. The prescaler clears on every stage start.
- States: IDLE, RUN, SUSTAIN.
- Start (rise seen, any state, ena high) at edge n:
  - S <= envOut; stage <= 0; t <= 0; state <= RUN.
  - envOut holds S, so there is no discontinuity. Retrigger mid-run is legato from the current value.
- RUN, per stage k with T = min(times[k], MAXLOG), D = levels[k] - S computed as BITS+1 signed:
  - Output: envOut = S + ((D * t) >>> T), with product width BITS+1+MAXLOG.
  - On each tick with t < 2^T-1: t increments.
  - On a tick with t == 2^T-1 (end of stage): envOut <= levels[k] exactly; S <= levels[k]; t <= 0.
  - T = 0 gives a one-tick stage.
- Next-state at end of stage k:
  - If sus_on and k == sustain_stage and gate is high: go to SUSTAIN.
  - Else if k < STAGES-1: stage k+1.
  - Else if loop_en: stage 0, with S = levels[STAGES-1].
  - Else: IDLE, busy=0, envOut holds levels[STAGES-1].
- SUSTAIN: envOut holds. When gate goes low, enter stage k+1 on the next cycle; if k is the last stage, apply the loop/IDLE rule instead.
- Gate already low on arrival at the sustain stage: no sustain, continue immediately.
- Simultaneous trigger rise and end of stage: the trigger wins (restart from the levels[k] value written that cycle).
- ena low: no state, counter or output changes. Resumes exactly where it left off.
- Inputs levels, times and sustain_stage are sampled live. Changing them mid-stage takes effect immediately and may jump envOut; no smoothing.

Optional Feature:
- Macro: ENVSEQ_RAMP_EOC_EN.
- Defined: adds output port eoc (1 bit), a one-cycle pulse on every end-of-stage event, and on entry to IDLE. Reset value 0; no pulse on SUSTAIN exit.
- Undefined: the port is absent and the logic is not built.
- Core timing is identical in both cases.

Test Plan:
- Basic ramp. Setup: BITS=16, STAGES=4, TSCALE=1; levels = {0x4000, 0x2000, 0x2000, 0}; times = {2,1,0,3}; sus_on=0; loop_en=0. Stimulus: trigger rise from envOut=0. Response:
  - stage 0: envOut 0, 0x1000, 0x2000, 0x3000, 0x4000.
  - stage 1: 0x4000 down to 0x2000 via 0x3000.
  - stage 2: a one-tick hold.
  - stage 3: down to 0 in 8 ticks.
  - then busy=0 and envOut=0.
- Sustain. Setup: sus_on=1, sustain_stage=1, gate high. Response: envOut holds 0x2000 and busy=1 for 50 cycles. Stimulus: gate low. Response: stage 2 is entered one cycle later.
- Legato retrigger. Stimulus: retrigger during stage 3 at envOut=0x1000. Response: stage=0; envOut=0x1000, ramping to 0x4000 in 4 ticks; no jump.
- Prescale and ena. Setup: TSCALE=3; ena held low for 5 cycles mid-stage. Response: envOut is stationary while ena is low; stage timing is stretched by exactly 5 cycles.
- Loop. Setup: loop_en=1. Response: after stage 3 ends at 0, stage 0 restarts from 0 with busy held at 1. Stimulus: rst low for one cycle. Response: envOut=0, busy=0, stage=0 on the next cycle.
- EOC (with ENVSEQ_RAMP_EOC_EN defined). Response: exactly 4 one-cycle eoc pulses per non-looping run, coincident with the cycles where envOut equals levels[k].
